// File: rtl/hps_drv_pkg.sv
// Shared constants for the HPS lightweight-bridge register slave:
// register offsets, STATUS bit positions and the block version word.
package hps_drv_pkg;

    localparam logic [31:0] VERSION = 32'h0002_0000;

    localparam int unsigned OFF_ID       = 32'h00;
    localparam int unsigned OFF_TX_DATA  = 32'h04;
    localparam int unsigned OFF_CTRL     = 32'h08;
    localparam int unsigned OFF_STATUS   = 32'h0C;
    localparam int unsigned OFF_RX_SEL   = 32'h10;
    localparam int unsigned OFF_RX_SIZE  = 32'h14;
    localparam int unsigned OFF_RX_DATA  = 32'h18;
    localparam int unsigned OFF_IRQ_STAT = 32'h1C;
    localparam int unsigned OFF_IRQ_MASK = 32'h20;
    localparam int unsigned OFF_RX_THR   = 32'h24;
    localparam int unsigned OFF_CMP_THR  = 32'h28;
    localparam int unsigned OFF_GUARD    = 32'h2C;
    localparam int unsigned OFF_MEM_ADDR = 32'h30;
    localparam int unsigned OFF_END_ADDR = 32'h34;
    localparam int unsigned OFF_TSTAMP   = 32'h38;

    localparam int STAT_TX_READY = 0;
    localparam int STAT_TX_OVF   = 1;
    localparam int STAT_RX_UNF   = 2;

    // A single channel still needs a one-bit select register.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hps_irq_ctrl.sv
// Sticky interrupt status with write-one-to-clear, enable mask and a
// registered level interrupt; a new event beats a clear in the same cycle.
module hps_irq_ctrl #(
    parameter int IRQ_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IRQ_W-1:0] irq_src,
    input  logic             mask_we,
    input  logic             clr_we,
    input  logic [IRQ_W-1:0] wdata,
    output logic [IRQ_W-1:0] status,
    output logic [IRQ_W-1:0] mask,
    output logic             irq
);

    logic [IRQ_W-1:0] clr_bits;

    assign clr_bits = clr_we ? wdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status <= '0;
            mask   <= '0;
            irq    <= 1'b0;
        end else begin
            status <= (status & ~clr_bits) | irq_src;
            if (mask_we) begin
                mask <= wdata;
            end
            irq <= |(status & mask);
        end
    end

endmodule

// File: rtl/hps_mm_bridge.sv
// Avalon-MM slave linking the HPS lightweight bridge to the modem datapath.
// Define HPS_DRV_TSTAMP_EN to add the irq-rise cycle timestamp (TSTAMP, ID bit31).
module hps_mm_bridge
    import hps_drv_pkg::*;
#(
    parameter int          ADDR_W      = 8,
    parameter int          FIFO_W      = 8,
    parameter int          N_CH        = 4,
    parameter int          IRQ_W       = 8,
    parameter logic [31:0] RX_THR_RST  = 32'd600,
    parameter logic [31:0] CMP_THR_RST = 32'd6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_W-1:0]      address,
    input  logic                   chipselect,
    input  logic                   read_en,
    input  logic                   write_en,
    input  logic [31:0]            writedata,
    output logic [31:0]            readdata,
    output logic [FIFO_W-1:0]      tx_data,
    output logic                   tx_wren,
    input  logic                   tx_ready,
    output logic                   start_tx,
    output logic                   navig_start,
    input  logic [N_CH*FIFO_W-1:0] rx_data,
    input  logic [N_CH*8-1:0]      rx_size,
    output logic [N_CH-1:0]        rx_rden,
    input  logic [IRQ_W-1:0]       irq_src,
    output logic                   irq,
    output logic [31:0]            rx_threshold,
    output logic [31:0]            comp_threshold,
    output logic [31:0]            guard_interval,
    output logic [31:0]            mem_addr,
    input  logic [31:0]            end_address
);

    localparam int CH_W = ch_width(N_CH);

    logic              wr, rd;
    logic [CH_W-1:0]   rx_sel, sel_w, sel_clamped;
    logic [FIFO_W-1:0] heads [N_CH];
    logic [7:0]        sizes [N_CH];
    logic [FIFO_W-1:0] sel_head;
    logic [7:0]        sel_size;
    logic              tx_ovf, rx_unf;
    logic              tx_ovf_set, tx_ovf_clr, rx_unf_set, rx_unf_clr, pop;
    logic              irq_mask_we, irq_clr_we;
    logic [IRQ_W-1:0]  irq_status, irq_mask;
    logic [31:0]       rd_val, id_word, tstamp_rd;

    // A simultaneous write drops the read, so the read qualifier excludes write_en.
    assign wr = chipselect & write_en;
    assign rd = chipselect & read_en & ~write_en;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            heads[i] = rx_data[i*FIFO_W +: FIFO_W];
            sizes[i] = rx_size[i*8 +: 8];
        end
    end

    assign sel_head    = heads[rx_sel];
    assign sel_size    = sizes[rx_sel];
    assign sel_w       = writedata[CH_W-1:0];
    assign sel_clamped = (int'(sel_w) >= N_CH) ? CH_W'(N_CH - 1) : sel_w;

    assign tx_ovf_set  = wr && (address == ADDR_W'(OFF_TX_DATA)) && !tx_ready;
    assign tx_ovf_clr  = wr && (address == ADDR_W'(OFF_STATUS)) && writedata[STAT_TX_OVF];
    assign rx_unf_clr  = wr && (address == ADDR_W'(OFF_STATUS)) && writedata[STAT_RX_UNF];
    assign irq_mask_we = wr && (address == ADDR_W'(OFF_IRQ_MASK));
    assign irq_clr_we  = wr && (address == ADDR_W'(OFF_IRQ_STAT));

    always_comb begin
        rd_val     = '0;
        pop        = 1'b0;
        rx_unf_set = 1'b0;
        case (address)
            ADDR_W'(OFF_ID):       rd_val = id_word;
            ADDR_W'(OFF_STATUS):   rd_val = 32'({rx_unf, tx_ovf, tx_ready});
            ADDR_W'(OFF_RX_SEL):   rd_val = 32'(rx_sel);
            ADDR_W'(OFF_RX_SIZE):  rd_val = 32'(sel_size);
            ADDR_W'(OFF_RX_DATA): begin
                if (sel_size != 8'd0) begin
                    rd_val = 32'(sel_head);
                    pop    = rd;
                end else begin
                    rx_unf_set = rd;
                end
            end
            ADDR_W'(OFF_IRQ_STAT): rd_val = 32'(irq_status);
            ADDR_W'(OFF_IRQ_MASK): rd_val = 32'(irq_mask);
            ADDR_W'(OFF_RX_THR):   rd_val = rx_threshold;
            ADDR_W'(OFF_CMP_THR):  rd_val = comp_threshold;
            ADDR_W'(OFF_GUARD):    rd_val = guard_interval;
            ADDR_W'(OFF_MEM_ADDR): rd_val = mem_addr;
            ADDR_W'(OFF_END_ADDR): rd_val = end_address;
            ADDR_W'(OFF_TSTAMP):   rd_val = tstamp_rd;
            default:               rd_val = '0;
        endcase
    end

    // Strobes default low every cycle so each access yields exactly one pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata       <= '0;
            tx_data        <= '0;
            tx_wren        <= 1'b0;
            start_tx       <= 1'b0;
            navig_start    <= 1'b0;
            rx_rden        <= '0;
            tx_ovf         <= 1'b0;
            rx_unf         <= 1'b0;
            rx_sel         <= '0;
            rx_threshold   <= RX_THR_RST;
            comp_threshold <= CMP_THR_RST;
            guard_interval <= '0;
            mem_addr       <= '0;
        end else begin
            tx_wren     <= 1'b0;
            start_tx    <= 1'b0;
            navig_start <= 1'b0;
            rx_rden     <= '0;
            if (rd) begin
                readdata <= rd_val;
            end
            if (pop) begin
                rx_rden <= N_CH'(1) << rx_sel;
            end
            tx_ovf <= tx_ovf_set | (tx_ovf & ~tx_ovf_clr);
            rx_unf <= rx_unf_set | (rx_unf & ~rx_unf_clr);
            if (wr) begin
                case (address)
                    ADDR_W'(OFF_TX_DATA): begin
                        if (tx_ready) begin
                            tx_wren <= 1'b1;
                            tx_data <= writedata[FIFO_W-1:0];
                        end
                    end
                    ADDR_W'(OFF_CTRL): begin
                        start_tx    <= writedata[0];
                        navig_start <= writedata[1];
                    end
                    ADDR_W'(OFF_RX_SEL):   rx_sel         <= sel_clamped;
                    ADDR_W'(OFF_RX_THR):   rx_threshold   <= writedata;
                    ADDR_W'(OFF_CMP_THR):  comp_threshold <= writedata;
                    ADDR_W'(OFF_GUARD):    guard_interval <= writedata;
                    ADDR_W'(OFF_MEM_ADDR): mem_addr       <= writedata;
                    default: ;
                endcase
            end
        end
    end

    hps_irq_ctrl #(
        .IRQ_W(IRQ_W)
    ) u_irq_ctrl (
        .clk     (clk),
        .reset_n (reset_n),
        .irq_src (irq_src),
        .mask_we (irq_mask_we),
        .clr_we  (irq_clr_we),
        .wdata   (writedata[IRQ_W-1:0]),
        .status  (irq_status),
        .mask    (irq_mask),
        .irq     (irq)
    );

`ifdef HPS_DRV_TSTAMP_EN
    logic [31:0] cycle_cnt;
    logic [31:0] tstamp;
    logic        irq_q;

    // The snapshot is the counter value during the first cycle irq is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
            tstamp    <= '0;
            irq_q     <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            irq_q     <= irq;
            if (irq && !irq_q) begin
                tstamp <= cycle_cnt;
            end
        end
    end

    assign tstamp_rd = tstamp;
    assign id_word   = {1'b1, VERSION[30:0]};
`else
    assign tstamp_rd = '0;
    assign id_word   = {1'b0, VERSION[30:0]};
`endif

endmodule

// File: tb/tb_hps_mm_bridge.sv
// Directed self-checking bench for hps_mm_bridge: register map, TX push,
// RX pop/underflow, interrupt masking and W1C, access priority and reset.
module tb_hps_mm_bridge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read_en = 1'b0;
    logic        write_en = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  tx_data;
    logic        tx_wren;
    logic        tx_ready = 1'b1;
    logic        start_tx;
    logic        navig_start;
    logic [31:0] rx_data = '0;
    logic [31:0] rx_size = '0;
    logic [3:0]  rx_rden;
    logic [7:0]  irq_src = '0;
    logic        irq;
    logic [31:0] rx_threshold, comp_threshold, guard_interval, mem_addr;
    logic [31:0] end_address = '0;

    int tests_run = 0;
    int failed = 0;

`ifdef HPS_DRV_TSTAMP_EN
    localparam logic [31:0] ID_EXP = 32'h8002_0000;
`else
    localparam logic [31:0] ID_EXP = 32'h0002_0000;
`endif

    hps_mm_bridge dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .address        (address),
        .chipselect     (chipselect),
        .read_en        (read_en),
        .write_en       (write_en),
        .writedata      (writedata),
        .readdata       (readdata),
        .tx_data        (tx_data),
        .tx_wren        (tx_wren),
        .tx_ready       (tx_ready),
        .start_tx       (start_tx),
        .navig_start    (navig_start),
        .rx_data        (rx_data),
        .rx_size        (rx_size),
        .rx_rden        (rx_rden),
        .irq_src        (irq_src),
        .irq            (irq),
        .rx_threshold   (rx_threshold),
        .comp_threshold (comp_threshold),
        .guard_interval (guard_interval),
        .mem_addr       (mem_addr),
        .end_address    (end_address)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_en = 1'b1; read_en = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_en = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read_en = 1'b1; write_en = 1'b0; address = a;
        @(negedge clk);
        chipselect = 1'b0; read_en = 1'b0;
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({readdata, tx_data} !== 40'd0) begin
            failed++; $display("[TB] FAIL reset_data: got %h expected 0", {readdata, tx_data});
        end
        tests_run++;
        if ({tx_wren, start_tx, navig_start, irq, rx_rden} !== 8'd0) begin
            failed++; $display("[TB] FAIL reset_strobes: got %b expected 0", {tx_wren, start_tx, navig_start, irq, rx_rden});
        end
        tests_run++;
        if (rx_threshold !== 32'd600 || comp_threshold !== 32'd6) begin
            failed++; $display("[TB] FAIL reset_thr: got %0d/%0d expected 600/6", rx_threshold, comp_threshold);
        end
        tests_run++;
        if (guard_interval !== 32'd0 || mem_addr !== 32'd0) begin
            failed++; $display("[TB] FAIL reset_cfg: got %h/%h expected 0/0", guard_interval, mem_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(8'h24, d);
        tests_run++;
        if (d !== 32'd600) begin failed++; $display("[TB] FAIL read_rx_thr: got %0d expected 600", d); end
        bus_read(8'h28, d);
        tests_run++;
        if (d !== 32'd6) begin failed++; $display("[TB] FAIL read_cmp_thr: got %0d expected 6", d); end
        bus_read(8'h20, d);
        tests_run++;
        if (d !== 32'd0) begin failed++; $display("[TB] FAIL read_irq_mask: got %h expected 0", d); end
    endtask

    task automatic test_tx();
        logic [31:0] d;
        tx_ready = 1'b1;
        bus_write(8'h04, 32'h1A5);
        tests_run++;
        if (tx_wren !== 1'b1 || tx_data !== 8'hA5) begin
            failed++; $display("[TB] FAIL tx_push: got wren=%b data=%h expected 1/a5", tx_wren, tx_data);
        end
        @(negedge clk);
        tests_run++;
        if (tx_wren !== 1'b0) begin failed++; $display("[TB] FAIL tx_pulse_len: got %b expected 0", tx_wren); end
        tx_ready = 1'b0;
        bus_write(8'h04, 32'h5A);
        tests_run++;
        if (tx_wren !== 1'b0 || tx_data !== 8'hA5) begin
            failed++; $display("[TB] FAIL tx_blocked: got wren=%b data=%h expected 0/a5", tx_wren, tx_data);
        end
        bus_read(8'h0C, d);
        tests_run++;
        if (d !== 32'h2) begin failed++; $display("[TB] FAIL tx_ovf_status: got %h expected 2", d); end
        bus_write(8'h0C, 32'h2);
        bus_read(8'h0C, d);
        tests_run++;
        if (d !== 32'h0) begin failed++; $display("[TB] FAIL tx_ovf_w1c: got %h expected 0", d); end
        tx_ready = 1'b1;
        bus_read(8'h0C, d);
        tests_run++;
        if (d !== 32'h1) begin failed++; $display("[TB] FAIL tx_ready_live: got %h expected 1", d); end
    endtask

    task automatic test_ctrl();
        bus_write(8'h08, 32'h3);
        tests_run++;
        if ({start_tx, navig_start} !== 2'b11) begin
            failed++; $display("[TB] FAIL ctrl_both: got %b expected 11", {start_tx, navig_start});
        end
        @(negedge clk);
        tests_run++;
        if ({start_tx, navig_start} !== 2'b00) begin
            failed++; $display("[TB] FAIL ctrl_pulse_len: got %b expected 00", {start_tx, navig_start});
        end
        bus_write(8'h08, 32'h2);
        tests_run++;
        if ({start_tx, navig_start} !== 2'b01) begin
            failed++; $display("[TB] FAIL ctrl_navig: got %b expected 01", {start_tx, navig_start});
        end
    endtask

    task automatic test_rx();
        logic [31:0] d;
        rx_data = {8'h44, 8'h3C, 8'h22, 8'h11};
        rx_size = {8'd0, 8'd3, 8'd0, 8'd5};
        bus_write(8'h10, 32'h2);
        bus_read(8'h10, d);
        tests_run++;
        if (d !== 32'h2) begin failed++; $display("[TB] FAIL rx_sel_read: got %h expected 2", d); end
        bus_read(8'h14, d);
        tests_run++;
        if (d !== 32'd3) begin failed++; $display("[TB] FAIL rx_size_read: got %0d expected 3", d); end
        // Three back-to-back reads: one pop per read, visible with each readdata update.
        @(negedge clk);
        chipselect = 1'b1; read_en = 1'b1; address = 8'h18;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) begin chipselect = 1'b0; read_en = 1'b0; end
            tests_run++;
            if (rx_rden !== 4'b0100 || readdata !== 32'h3C) begin
                failed++; $display("[TB] FAIL rx_pop_%0d: got rden=%b data=%h expected 0100/3c", i, rx_rden, readdata);
            end
        end
        @(negedge clk);
        tests_run++;
        if (rx_rden !== 4'b0000) begin failed++; $display("[TB] FAIL rx_pop_end: got %b expected 0000", rx_rden); end
        rx_size[23:16] = 8'd0;
        bus_read(8'h18, d);
        tests_run++;
        if (d !== 32'h0 || rx_rden !== 4'b0000) begin
            failed++; $display("[TB] FAIL rx_empty_read: got data=%h rden=%b expected 0/0000", d, rx_rden);
        end
        bus_read(8'h0C, d);
        tests_run++;
        if (d !== 32'h5) begin failed++; $display("[TB] FAIL rx_unf_status: got %h expected 5", d); end
        bus_write(8'h0C, 32'h4);
        bus_read(8'h0C, d);
        tests_run++;
        if (d !== 32'h1) begin failed++; $display("[TB] FAIL rx_unf_w1c: got %h expected 1", d); end
        bus_write(8'h10, 32'h7);
        bus_read(8'h10, d);
        tests_run++;
        if (d !== 32'h3) begin failed++; $display("[TB] FAIL rx_sel_trunc: got %h expected 3", d); end
        bus_write(8'h10, 32'h0);
        bus_read(8'h18, d);
        tests_run++;
        if (d !== 32'h11 || rx_rden !== 4'b0001) begin
            failed++; $display("[TB] FAIL rx_pop_ch0: got data=%h rden=%b expected 11/0001", d, rx_rden);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        @(negedge clk); irq_src = 8'h20;
        @(negedge clk); irq_src = 8'h00;
        repeat (2) @(negedge clk);
        tests_run++;
        if (irq !== 1'b0) begin failed++; $display("[TB] FAIL irq_masked: got %b expected 0", irq); end
        bus_read(8'h1C, d);
        tests_run++;
        if (d !== 32'h20) begin failed++; $display("[TB] FAIL irq_stat_sticky: got %h expected 20", d); end
        bus_write(8'h20, 32'h20);
        tests_run++;
        if (irq !== 1'b0) begin failed++; $display("[TB] FAIL irq_unmask_lat: got %b expected 0", irq); end
        @(negedge clk);
        tests_run++;
        if (irq !== 1'b1) begin failed++; $display("[TB] FAIL irq_unmask_rise: got %b expected 1", irq); end
        // Clear and a new event on the same bit in one cycle: the event wins.
        @(negedge clk);
        chipselect = 1'b1; write_en = 1'b1; address = 8'h1C; writedata = 32'h20; irq_src = 8'h20;
        @(negedge clk);
        chipselect = 1'b0; write_en = 1'b0; irq_src = 8'h00;
        bus_read(8'h1C, d);
        tests_run++;
        if (d !== 32'h20 || irq !== 1'b1) begin
            failed++; $display("[TB] FAIL irq_set_wins: got stat=%h irq=%b expected 20/1", d, irq);
        end
        bus_write(8'h1C, 32'h20);
        tests_run++;
        if (irq !== 1'b1) begin failed++; $display("[TB] FAIL irq_clr_lat: got %b expected 1", irq); end
        @(negedge clk);
        tests_run++;
        if (irq !== 1'b0) begin failed++; $display("[TB] FAIL irq_clr_drop: got %b expected 0", irq); end
        @(negedge clk); irq_src = 8'h21;
        @(negedge clk); irq_src = 8'h00;
        @(negedge clk);
        tests_run++;
        if (irq !== 1'b1) begin failed++; $display("[TB] FAIL irq_event_rise: got %b expected 1", irq); end
        bus_write(8'h20, 32'h00);
        @(negedge clk);
        tests_run++;
        if (irq !== 1'b0) begin failed++; $display("[TB] FAIL irq_mask_drop: got %b expected 0", irq); end
        bus_read(8'h1C, d);
        tests_run++;
        if (d !== 32'h21) begin failed++; $display("[TB] FAIL irq_stat_kept: got %h expected 21", d); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        bus_read(8'h00, d);
        tests_run++;
        if (d !== ID_EXP) begin failed++; $display("[TB] FAIL id_read: got %h expected %h", d, ID_EXP); end
        @(negedge clk);
        chipselect = 1'b1; read_en = 1'b1; write_en = 1'b1; address = 8'h30; writedata = 32'hDEAD;
        @(negedge clk);
        chipselect = 1'b0; read_en = 1'b0; write_en = 1'b0;
        tests_run++;
        if (mem_addr !== 32'hDEAD || readdata !== ID_EXP || rx_rden !== 4'b0000) begin
            failed++; $display("[TB] FAIL rw_priority: got mem=%h rd=%h rden=%b expected dead/%h/0000", mem_addr, readdata, rx_rden, ID_EXP);
        end
        @(negedge clk);
        chipselect = 1'b1; read_en = 1'b1; write_en = 1'b1; address = 8'h18; writedata = 32'h0;
        @(negedge clk);
        chipselect = 1'b0; read_en = 1'b0; write_en = 1'b0;
        tests_run++;
        if (readdata !== ID_EXP || rx_rden !== 4'b0000) begin
            failed++; $display("[TB] FAIL rw_no_pop: got rd=%h rden=%b expected %h/0000", readdata, rx_rden, ID_EXP);
        end
    endtask

    task automatic test_misc();
        logic [31:0] d;
        bus_write(8'h2C, 32'h1234_5678);
        bus_read(8'h2C, d);
        tests_run++;
        if (guard_interval !== 32'h1234_5678 || d !== 32'h1234_5678) begin
            failed++; $display("[TB] FAIL guard_rw: got %h/%h expected 12345678", guard_interval, d);
        end
        bus_write(8'h24, 32'd1000);
        bus_read(8'h24, d);
        tests_run++;
        if (d !== 32'd1000 || rx_threshold !== 32'd1000) begin
            failed++; $display("[TB] FAIL rx_thr_rw: got %0d/%0d expected 1000", d, rx_threshold);
        end
        end_address = 32'hCAFE_BABE;
        bus_read(8'h34, d);
        tests_run++;
        if (d !== 32'hCAFE_BABE) begin failed++; $display("[TB] FAIL end_addr: got %h expected cafebabe", d); end
        bus_write(8'h3C, 32'hFFFF_FFFF);
        bus_read(8'h3C, d);
        tests_run++;
        if (d !== 32'h0) begin failed++; $display("[TB] FAIL unmapped: got %h expected 0", d); end
`ifndef HPS_DRV_TSTAMP_EN
        bus_read(8'h38, d);
        tests_run++;
        if (d !== 32'h0) begin failed++; $display("[TB] FAIL tstamp_off: got %h expected 0", d); end
`endif
    endtask

    task automatic test_reset_midaccess();
        tx_ready = 1'b1;
        @(negedge clk);
        chipselect = 1'b1; write_en = 1'b1; address = 8'h04; writedata = 32'h55;
        #2 reset_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_en = 1'b0;
        tests_run++;
        if (tx_wren !== 1'b0 || tx_data !== 8'h00 || mem_addr !== 32'h0) begin
            failed++; $display("[TB] FAIL reset_abort: got wren=%b data=%h mem=%h expected 0/00/0", tx_wren, tx_data, mem_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (tx_wren !== 1'b0) begin failed++; $display("[TB] FAIL reset_release: got %b expected 0", tx_wren); end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_ctrl();
        test_rx();
        test_irq();
        test_simultaneous();
        test_misc();
        test_reset_midaccess();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
